fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter NRD, default 2, meaning number of operand read ports.
REQ-003 The block SHALL have parameter NSTG, default 3, meaning number of tracked producer stages after decode (stage 0 = EX, youngest).
REQ-004 The block SHALL have these ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill all in-flight tracking entries
pipe_adv  in  1  pipeline advances this cycle
id_vld  in  1  decode stage holds an instruction
id_rd  in  5  decode destination register
id_we  in  1  decode instruction writes id_rd
id_rs  in  NRD*5  source register addresses, port i at [5i+4:5i]
id_rs_use  in  NRD  port i operand is consumed
regs_rddata  in  NRD*XLEN  register-file read data per port
stg_data  in  NSTG*XLEN  result value held in stage s
stg_rdy  in  NSTG  stg_data[s] is final (0 for load not yet returned)
of_x_rs  out  NRD*XLEN  forwarded operand per port
stall  out  1  decode instruction must hold
id_accept  out  1  decode instruction moves into stage 0 this edge
trk_busy  out  NSTG  stage s holds a live writer
stall_cnt  out  32  cycles spent stalled

Function
REQ-005 Tracking entry per stage SHALL hold {live, rd}; live set only when id_we=1 and id_rd!=0.
REQ-006 Operand select SHALL be combinational (zero latency): for port i, take the youngest stage s with live[s]=1 and rd[s]==id_rs[i] and id_rs[i]!=0; output stg_data[s], else regs_rddata[i].
REQ-007 Older matching stages SHALL be ignored when a younger stage matches.
REQ-008 Port i SHALL be hazardous when id_vld, id_rs_use[i], a match exists, and stg_rdy of the youngest matching stage is 0.
REQ-009 stall SHALL be 1 when any port is hazardous and flush=0; otherwise 0.
REQ-010 id_accept SHALL equal id_vld & !stall & pipe_adv & !flush.
REQ-011 On an edge with pipe_adv=1 and flush=0, entry s SHALL take entry s-1 for s>=1, and entry 0 SHALL load {id_we&&id_rd!=0, id_rd} if id_accept else a bubble (live=0).
REQ-012 On an edge with pipe_adv=0 and flush=0, all entries SHALL hold.
REQ-013 The entry leaving stage NSTG-1 SHALL be dropped; register file is written on that edge, so regs_rddata covers it next cycle.
REQ-014 flush SHALL clear every live bit at the edge, with priority over pipe_adv; of_x_rs still forwards from pre-flush entries during the flush cycle.
REQ-015 stall_cnt SHALL increment by 1 on each edge where stall=1, saturating at 32'hFFFF_FFFF; flush does not clear it.
REQ-016 trk_busy[s] SHALL equal live[s].
REQ-017 Both ports matching the same stage SHALL both forward that stage's data.

Reset
REQ-018 On rst=1 at an edge, all live bits and stall_cnt SHALL be 0; rst SHALL dominate flush and pipe_adv.
REQ-019 While entries are clear after reset, stall=0, trk_busy=0, of_x_rs=regs_rddata.

Structure
REQ-020 Shared defines SHALL hold REG_ADDR_W=5, REG_ZERO=5'd0 and default XLEN/NRD/NSTG values.
REQ-021 Per-port select/hazard logic SHALL be sub-module fwd_port_sel, instantiated NRD times by generate.
REQ-022 Tracking entries SHALL be the only state besides stall_cnt; no data is registered inside the block.

Verification
REQ-023 Entry0 {rd=5, live}, stg_rdy[0]=1, stg_data[0]=32'hA5A5_0001, id_rs port0=5 use=1 -> of_x_rs port0=32'hA5A5_0001, stall=0.
REQ-024 Entry0 rd=5, entry1 rd=5, stg_data[0]=1, stg_data[1]=2, both ready -> port0 reads 1 (youngest wins).
REQ-025 Load in stage0 rd=7 stg_rdy[0]=0, id_rs port1=7 use=1, pipe_adv=1 -> stall=1, id_accept=0; next edge bubble enters stage0, stall_cnt=1; stg_rdy[1]=1 then -> stall=0, forward stg_data[1].
REQ-026 id_rd=0 id_we=1 accepted, then id_rs=0 -> no match, of_x_rs=regs_rddata, trk_busy[0]=0.
REQ-027 Three live entries, flush=1 with pipe_adv=1 -> next cycle trk_busy=0, stall_cnt unchanged; rst=1 -> stall_cnt=0.
REQ-028 Force stall for 2^32+3 cycles (or preload via force) -> stall_cnt holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared register-address constants, default sizes and the tracking-entry type
// for the operand forwarding scoreboard.
package fwd_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NRD_DEF  = 2;
    localparam int unsigned NSTG_DEF = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      live;
        reg_addr_t rd;
    } trk_entry_t;

endpackage

// File: rtl/fwd_port_sel.sv
// One operand read port: picks the youngest live producer of rs_i, falling back
// to register-file data, and flags a hazard when that producer is not ready.
module fwd_port_sel
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NSTG = NSTG_DEF
) (
    input  logic                   id_vld_i,
    input  logic                   rs_use_i,
    input  reg_addr_t              rs_i,
    input  trk_entry_t [NSTG-1:0]  trk_i,
    input  logic [NSTG*XLEN-1:0]   stg_data_i,
    input  logic [NSTG-1:0]        stg_rdy_i,
    input  logic [XLEN-1:0]        rf_data_i,
    output logic [XLEN-1:0]        data_o,
    output logic                   hazard_o
);

    logic hit;
    logic hit_rdy;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        data_o  = rf_data_i;
        hit     = 1'b0;
        hit_rdy = 1'b1;
        for (int s = NSTG - 1; s >= 0; s--) begin
            if (trk_i[s].live && (trk_i[s].rd == rs_i) && (rs_i != REG_ZERO)) begin
                hit     = 1'b1;
                hit_rdy = stg_rdy_i[s];
                data_o  = stg_data_i[s*XLEN +: XLEN];
            end
        end
        hazard_o = id_vld_i & rs_use_i & hit & ~hit_rdy;
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Tracks destination registers of in-flight producers after decode, forwards
// their results to decode operands and stalls decode on not-yet-ready results.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NRD  = NRD_DEF,
    parameter int unsigned NSTG = NSTG_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        pipe_adv,
    input  logic                        id_vld,
    input  logic [REG_ADDR_W-1:0]       id_rd,
    input  logic                        id_we,
    input  logic [NRD*REG_ADDR_W-1:0]   id_rs,
    input  logic [NRD-1:0]              id_rs_use,
    input  logic [NRD*XLEN-1:0]         regs_rddata,
    input  logic [NSTG*XLEN-1:0]        stg_data,
    input  logic [NSTG-1:0]             stg_rdy,
    output logic [NRD*XLEN-1:0]         of_x_rs,
    output logic                        stall,
    output logic                        id_accept,
    output logic [NSTG-1:0]             trk_busy,
    output logic [31:0]                 stall_cnt
);

    trk_entry_t [NSTG-1:0] trk_q, trk_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
    logic [NRD-1:0]        hazard;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        fwd_port_sel #(
            .XLEN (XLEN),
            .NSTG (NSTG)
        ) u_sel (
            .id_vld_i   (id_vld),
            .rs_use_i   (id_rs_use[i]),
            .rs_i       (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .trk_i      (trk_q),
            .stg_data_i (stg_data),
            .stg_rdy_i  (stg_rdy),
            .rf_data_i  (regs_rddata[i*XLEN +: XLEN]),
            .data_o     (of_x_rs[i*XLEN +: XLEN]),
            .hazard_o   (hazard[i])
        );
    end

    assign stall     = (|hazard) & ~flush;
    assign id_accept = id_vld & ~stall & pipe_adv & ~flush;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        for (int s = 0; s < NSTG; s++) begin
            trk_busy[s] = trk_q[s].live;
        end
    end

    always_comb begin
        trk_d = trk_q;
        if (flush) begin
            for (int s = 0; s < NSTG; s++) begin
                trk_d[s].live = 1'b0;
            end
        end else if (pipe_adv) begin
            // The oldest entry falls off; the register file holds it from now on.
            for (int s = NSTG - 1; s >= 1; s--) begin
                trk_d[s] = trk_q[s-1];
            end
            trk_d[0].live = id_accept & id_we & (id_rd != REG_ZERO);
            trk_d[0].rd   = id_rd;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_q       <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            trk_q       <= trk_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized
// traffic against a list-of-producers reference model.
module tb_fwd_scoreboard;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int NSTG = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 pipe_adv;
    logic                 id_vld;
    logic [4:0]           id_rd;
    logic                 id_we;
    logic [NRD*5-1:0]     id_rs;
    logic [NRD-1:0]       id_rs_use;
    logic [NRD*XLEN-1:0]  regs_rddata;
    logic [NSTG*XLEN-1:0] stg_data;
    logic [NSTG-1:0]      stg_rdy;
    logic [NRD*XLEN-1:0]  of_x_rs;
    logic                 stall;
    logic                 id_accept;
    logic [NSTG-1:0]      trk_busy;
    logic [31:0]          stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    fwd_scoreboard #(
        .XLEN (XLEN),
        .NRD  (NRD),
        .NSTG (NSTG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .pipe_adv    (pipe_adv),
        .id_vld      (id_vld),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_rs       (id_rs),
        .id_rs_use   (id_rs_use),
        .regs_rddata (regs_rddata),
        .stg_data    (stg_data),
        .stg_rdy     (stg_rdy),
        .of_x_rs     (of_x_rs),
        .stall       (stall),
        .id_accept   (id_accept),
        .trk_busy    (trk_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: per-stage producer list, index 0 is youngest.
    logic       m_live [NSTG] = '{default: 1'b0};
    logic [4:0] m_rd   [NSTG] = '{default: 5'd0};
    logic [31:0] m_cnt = 32'd0;

    function automatic int m_youngest(input logic [4:0] rs);
        for (int s = 0; s < NSTG; s++) begin
            if (m_live[s] && m_rd[s] == rs && rs != 5'd0) return s;
        end
        return -1;
    endfunction

    function automatic logic m_stall();
        if (flush) return 1'b0;
        for (int i = 0; i < NRD; i++) begin
            int y;
            y = m_youngest(id_rs[i*5 +: 5]);
            if (id_vld && id_rs_use[i] && y >= 0 && !stg_rdy[y]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NRD*XLEN-1:0] m_fwd();
        logic [NRD*XLEN-1:0] r;
        for (int i = 0; i < NRD; i++) begin
            int y;
            y = m_youngest(id_rs[i*5 +: 5]);
            r[i*XLEN +: XLEN] = (y >= 0) ? stg_data[y*XLEN +: XLEN] : regs_rddata[i*XLEN +: XLEN];
        end
        return r;
    endfunction

    function automatic logic [NSTG-1:0] m_busy();
        logic [NSTG-1:0] b;
        for (int s = 0; s < NSTG; s++) b[s] = m_live[s];
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTG; s++) m_live[s] <= 1'b0;
            m_cnt <= 32'd0;
        end else begin
            if (m_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
            if (flush) begin
                for (int s = 0; s < NSTG; s++) m_live[s] <= 1'b0;
            end else if (pipe_adv) begin
                for (int s = 1; s < NSTG; s++) begin
                    m_live[s] <= m_live[s-1];
                    m_rd[s]   <= m_rd[s-1];
                end
                m_live[0] <= id_vld && !m_stall() && id_we && id_rd != 5'd0;
                m_rd[0]   <= id_rd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; pipe_adv = 0; id_vld = 0; id_rd = 0; id_we = 0;
        id_rs = '0; id_rs_use = '0; stg_rdy = '1;
        regs_rddata = {32'h1111_0000, 32'h2222_0000};
        stg_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push(input logic [4:0] rd);
        id_vld = 1; id_we = 1; id_rd = rd; pipe_adv = 1; id_rs_use = '0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; flush = 1; pipe_adv = 1;
        tick();
        tick();
        rst = 0; flush = 0; pipe_adv = 0;
        id_vld = 1; id_rs = {5'd3, 5'd4}; id_rs_use = 2'b11; stg_rdy = '0;
        #1;
        n_vec++; if (trk_busy !== 3'b000) begin n_bad++; $display("FAIL reset_busy: got %b expected 000", trk_busy); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_vec++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %h expected 0", stall_cnt); end
        n_vec++; if (of_x_rs !== regs_rddata) begin n_bad++; $display("FAIL reset_fwd: got %h expected %h", of_x_rs, regs_rddata); end
    endtask

    task automatic test_forward_basic();
        do_reset();
        push(5'd5);
        stg_data[31:0] = 32'hA5A5_0001; stg_rdy = '1;
        id_vld = 1; id_rs[4:0] = 5'd5; id_rs_use = 2'b01;
        #1;
        n_vec++; if (of_x_rs[31:0] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL fwd_basic: got %h expected a5a50001", of_x_rs[31:0]); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fwd_basic_stall: got %b expected 0", stall); end
        n_vec++; if (trk_busy !== 3'b001) begin n_bad++; $display("FAIL fwd_basic_busy: got %b expected 001", trk_busy); end
    endtask

    task automatic test_youngest();
        do_reset();
        push(5'd5);
        push(5'd5);
        stg_data = {32'd3, 32'd2, 32'd1}; stg_rdy = '1;
        id_vld = 1; id_rs = {5'd5, 5'd5}; id_rs_use = 2'b11;
        #1;
        n_vec++; if (of_x_rs[31:0] !== 32'd1) begin n_bad++; $display("FAIL youngest_p0: got %h expected 1", of_x_rs[31:0]); end
        n_vec++; if (of_x_rs[63:32] !== 32'd1) begin n_bad++; $display("FAIL youngest_p1: got %h expected 1", of_x_rs[63:32]); end
    endtask

    task automatic test_load_stall();
        do_reset();
        push(5'd7);
        stg_rdy = 3'b110; stg_data = {32'hC0, 32'hB0, 32'hA0};
        id_vld = 1; id_we = 1; id_rd = 5'd3; id_rs = {5'd7, 5'd0}; id_rs_use = 2'b10; pipe_adv = 1;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_stall: got %b expected 1", stall); end
        n_vec++; if (id_accept !== 1'b0) begin n_bad++; $display("FAIL load_accept: got %b expected 0", id_accept); end
        tick();
        n_vec++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL load_cnt: got %h expected 1", stall_cnt); end
        n_vec++; if (trk_busy !== 3'b010) begin n_bad++; $display("FAIL load_bubble: got %b expected 010", trk_busy); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL load_release: got %b expected 0", stall); end
        n_vec++; if (of_x_rs[63:32] !== 32'hB0) begin n_bad++; $display("FAIL load_fwd: got %h expected b0", of_x_rs[63:32]); end
    endtask

    task automatic test_x0();
        do_reset();
        push(5'd0);
        id_vld = 1; id_rs = '0; id_rs_use = 2'b11; stg_rdy = '0;
        #1;
        n_vec++; if (trk_busy[0] !== 1'b0) begin n_bad++; $display("FAIL x0_busy: got %b expected 0", trk_busy[0]); end
        n_vec++; if (of_x_rs !== regs_rddata) begin n_bad++; $display("FAIL x0_fwd: got %h expected %h", of_x_rs, regs_rddata); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall: got %b expected 0", stall); end
    endtask

    task automatic test_flush();
        do_reset();
        push(5'd1);
        push(5'd2);
        push(5'd3);
        n_vec++; if (trk_busy !== 3'b111) begin n_bad++; $display("FAIL flush_fill: got %b expected 111", trk_busy); end
        id_vld = 1; id_rs[4:0] = 5'd3; id_rs_use = 2'b01; stg_rdy = '0;
        tick();
        n_vec++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL flush_precnt: got %h expected 1", stall_cnt); end
        flush = 1; pipe_adv = 1;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", stall); end
        n_vec++; if (id_accept !== 1'b0) begin n_bad++; $display("FAIL flush_accept: got %b expected 0", id_accept); end
        n_vec++; if (of_x_rs[31:0] !== 32'h3333_0000) begin n_bad++; $display("FAIL flush_fwd: got %h expected 33330000", of_x_rs[31:0]); end
        tick();
        flush = 0; pipe_adv = 0;
        #1;
        n_vec++; if (trk_busy !== 3'b000) begin n_bad++; $display("FAIL flush_busy: got %b expected 000", trk_busy); end
        n_vec++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL flush_cnt: got %h expected 1", stall_cnt); end
        rst = 1; flush = 1; pipe_adv = 1;
        tick();
        rst = 0; flush = 0; pipe_adv = 0;
        #1;
        n_vec++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL flush_rst_cnt: got %h expected 0", stall_cnt); end
    endtask

    task automatic test_saturate();
        logic [31:0] exp_cnt [4];
        exp_cnt[0] = 32'hFFFF_FFFD; exp_cnt[1] = 32'hFFFF_FFFE;
        exp_cnt[2] = 32'hFFFF_FFFF; exp_cnt[3] = 32'hFFFF_FFFF;
        do_reset();
        push(5'd9);
        id_vld = 1; id_rs[4:0] = 5'd9; id_rs_use = 2'b01; stg_rdy = '0;
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        m_cnt <= 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++; if (stall_cnt !== exp_cnt[k]) begin n_bad++; $display("FAIL sat_cnt%0d: got %h expected %h", k, stall_cnt, exp_cnt[k]); end
            if (k < 3) tick();
        end
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall: got %b expected 1", stall); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            flush       = ($urandom_range(0, 15) == 0);
            pipe_adv    = ($urandom_range(0, 3) != 0);
            id_vld      = $urandom_range(0, 1);
            id_we       = ($urandom_range(0, 3) != 0);
            id_rd       = 5'($urandom_range(0, 7));
            id_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_rs_use   = 2'($urandom_range(0, 3));
            stg_rdy     = 3'($urandom_range(0, 7));
            stg_data    = {$urandom, $urandom, $urandom};
            regs_rddata = {$urandom, $urandom};
            #1;
            n_vec++; if (of_x_rs !== m_fwd()) begin n_bad++; $display("FAIL rnd_fwd[%0d]: got %h expected %h", n, of_x_rs, m_fwd()); end
            n_vec++; if (stall !== m_stall()) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, stall, m_stall()); end
            n_vec++; if (id_accept !== (id_vld && !m_stall() && pipe_adv && !flush)) begin
                n_bad++; $display("FAIL rnd_accept[%0d]: got %b expected %b", n, id_accept, id_vld && !m_stall() && pipe_adv && !flush);
            end
            n_vec++; if (trk_busy !== m_busy()) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b expected %b", n, trk_busy, m_busy()); end
            n_vec++; if (stall_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %h expected %h", n, stall_cnt, m_cnt); end
            tick();
        end
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_forward_basic();
        test_youngest();
        test_load_stall();
        test_x0();
        test_flush();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
